// File: rtl/dcache_wbuf_pkg.sv
// dcache_wbuf_pkg: shared line sizes and FSM encodings for the data-cache write buffer
package dcache_wbuf_pkg;
    localparam int WB_DEPTH = 4;
    localparam int ADDR_W = 28;
    localparam int LINE_W = 128;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;
endpackage

// File: rtl/dcache_wbuf_if.sv
// dcache_wbuf_if: line-granular request/ready bus used on both the cache and memory sides
interface dcache_wbuf_if;
    import dcache_wbuf_pkg::*;
    logic              read;
    logic              write;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    modport master(output read, write, addr, wdata, input rdata, ready);
    modport slave(input read, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/dcache_wbuf_fifo.sv
// dcache_wbuf_fifo: line storage with head/tail/count and a parallel address match over live entries
module dcache_wbuf_fifo
    import dcache_wbuf_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic              o_hit,
    output logic              o_hit_is_head,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [LINE_W-1:0] o_head_data,
    output logic [LINE_W-1:0] o_hit_data
);
    localparam int PW = $clog2(DEPTH);
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [LINE_W-1:0] r_data [DEPTH];
    logic [PW-1:0]     r_head, r_tail, w_hit_idx;
    logic [PW:0]       r_count;
    // an entry is live when its distance from head is below count
    always_comb begin
        o_hit = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if ({1'b0, PW'(i) - r_head} < r_count && r_addr[i] == i_addr) begin
                o_hit = 1'b1;
                w_hit_idx = PW'(i);
            end
    end
    assign o_hit_is_head = o_hit && w_hit_idx == r_head;
    assign o_full = r_count == (PW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];
    assign o_hit_data = r_data[w_hit_idx];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_count <= '0;
        end else begin
            r_head <= r_head + PW'(i_pop);
            r_tail <= r_tail + PW'(i_push);
            r_count <= r_count + (PW+1)'(i_push) - (PW+1)'(i_pop);
        end
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_tail] <= i_addr;
            r_data[r_tail] <= i_wdata;
        end
        if (i_wr) r_data[w_hit_idx] <= i_wdata;
    end
endmodule

// File: rtl/dcache_wbuf.sv
// dcache_wbuf: absorbs cache write-back lines, serves read hits locally and drains to slow memory
module dcache_wbuf
    import dcache_wbuf_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic          clk,
    input  logic          proc_reset,
    dcache_wbuf_if.slave  c_bus,
    dcache_wbuf_if.master mem_bus
);
    logic [1:0]        r_state;
    logic              r_c_ready, r_mem_read, r_mem_write;
    logic [LINE_W-1:0] r_c_rdata, r_mem_wdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              w_hit, w_hit_head, w_full, w_empty;
    logic [ADDR_W-1:0] w_head_addr;
    logic [LINE_W-1:0] w_head_data, w_hit_data;
    logic              w_acc, w_rd, w_wr, w_pop, w_head_blk, w_coal, w_push, w_miss_go, w_drain_go, w_rd_done;
    // a request is never taken in the cycle its completion is still visible
    assign w_acc = !r_c_ready && r_state != ST_READ;
    assign w_rd = w_acc && c_bus.read;
    assign w_wr = w_acc && c_bus.write && !c_bus.read;
    assign w_pop = r_state == ST_DRAIN && mem_bus.ready;
    assign w_rd_done = r_state == ST_READ && mem_bus.ready;
    // the line in flight to memory must not change, so a write to it waits and becomes a new entry
    assign w_head_blk = w_hit && w_hit_head && r_state == ST_DRAIN;
    assign w_coal = w_wr && w_hit && !w_head_blk;
    assign w_push = w_wr && (!w_hit || w_head_blk) && ((!w_full && !w_head_blk) || w_pop);
    assign w_miss_go = w_rd && !w_hit && r_state == ST_IDLE;
    assign w_drain_go = r_state == ST_IDLE && !w_empty && !(w_rd && !w_hit);
    dcache_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk           (clk),
        .rst           (proc_reset),
        .i_push        (w_push),
        .i_pop         (w_pop),
        .i_wr          (w_coal),
        .i_addr        (c_bus.addr),
        .i_wdata       (c_bus.wdata),
        .o_hit         (w_hit),
        .o_hit_is_head (w_hit_head),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_head_addr   (w_head_addr),
        .o_head_data   (w_head_data),
        .o_hit_data    (w_hit_data)
    );
    always_ff @(posedge clk or posedge proc_reset)
        if (proc_reset) begin
            r_state <= ST_IDLE;
            r_c_ready <= 1'b0;
            r_c_rdata <= '0;
            r_mem_read <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_c_ready <= (w_rd && w_hit) || w_coal || w_push || w_rd_done;
            if (w_rd && w_hit) r_c_rdata <= w_hit_data;
            else if (w_rd_done) r_c_rdata <= mem_bus.rdata;
            if (w_miss_go) begin
                r_state <= ST_READ;
                r_mem_read <= 1'b1;
                r_mem_addr <= c_bus.addr;
            end else if (w_drain_go) begin
                r_state <= ST_DRAIN;
                r_mem_write <= 1'b1;
                r_mem_addr <= w_head_addr;
                r_mem_wdata <= (w_coal && w_hit_head) ? c_bus.wdata : w_head_data;
            end else if (mem_bus.ready && r_state != ST_IDLE) begin
                r_state <= ST_IDLE;
                r_mem_read <= 1'b0;
                r_mem_write <= 1'b0;
            end
        end
    assign c_bus.ready = r_c_ready;
    assign c_bus.rdata = r_c_rdata;
    assign mem_bus.read = r_mem_read;
    assign mem_bus.write = r_mem_write;
    assign mem_bus.addr = r_mem_addr;
    assign mem_bus.wdata = r_mem_wdata;
endmodule

// File: tb/tb_dcache_wbuf.sv
// tb_dcache_wbuf: directed vectors with hand-computed expectations for the write buffer
module tb_dcache_wbuf;
    logic clk = 1'b0;
    logic proc_reset;
    int   n_vec = 0;
    int   n_err = 0;
    logic [27:0]  wa[$];
    logic [127:0] wd[$];
    logic [27:0]  ra[$];
    localparam logic [127:0] DA = {4{32'hAAAA_0001}};
    localparam logic [127:0] DB = {4{32'hBBBB_0002}};
    localparam logic [127:0] DC = {4{32'hCCCC_0003}};
    localparam logic [127:0] DD = {4{32'hDDDD_0004}};
    localparam logic [127:0] DE = {4{32'hEEEE_0005}};
    localparam logic [127:0] DF = {4{32'hFFFF_0006}};
    localparam logic [127:0] DG = {4{32'h1234_0007}};
    localparam logic [127:0] DH = {4{32'h5678_0008}};
    localparam logic [127:0] DR = {4{32'h9ABC_0009}};

    dcache_wbuf_if c_bus();
    dcache_wbuf_if mem_bus();
    dcache_wbuf dut (.clk(clk), .proc_reset(proc_reset), .c_bus(c_bus), .mem_bus(mem_bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_bus.write && mem_bus.ready) begin
            wa.push_back(mem_bus.addr);
            wd.push_back(mem_bus.wdata);
        end
        if (mem_bus.read && mem_bus.ready) ra.push_back(mem_bus.addr);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_pulse(input logic [127:0] d);
        mem_bus.rdata = d;
        mem_bus.ready = 1'b1;
        step();
        mem_bus.ready = 1'b0;
    endtask

    task automatic cache_req(input logic rd, input logic [27:0] a, input logic [127:0] d,
                             output int cyc, output logic [127:0] q);
        c_bus.read = rd;
        c_bus.write = !rd;
        c_bus.addr = a;
        c_bus.wdata = d;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!c_bus.ready && cyc < 60);
        chk("req_ready", c_bus.ready, 1);
        q = c_bus.rdata;
        c_bus.read = 1'b0;
        c_bus.write = 1'b0;
        step();
    endtask

    task automatic drain_all();
        for (int k = 0; k < 100; k++) begin
            if (dut.u_fifo.r_count == 0 && !mem_bus.write) break;
            if (mem_bus.write) mem_pulse('0);
            else step();
        end
        chk("drain_count", dut.u_fifo.r_count, 0);
        chk("drain_wr", mem_bus.write, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, cyc5;
        logic [127:0] q, q5;
        logic [27:0]  exp_a[$];
        logic [127:0] exp_d[$];
        proc_reset = 1'b1;
        c_bus.read = 1'b0;
        c_bus.write = 1'b0;
        c_bus.addr = '0;
        c_bus.wdata = '0;
        mem_bus.ready = 1'b0;
        mem_bus.rdata = '0;
        step();
        step();
        chk("rst_c_ready", c_bus.ready, 0);
        chk("rst_mem_rd", mem_bus.read, 0);
        chk("rst_mem_wr", mem_bus.write, 0);
        chk("rst_mem_addr", mem_bus.addr, 0);
        chk("rst_count", dut.u_fifo.r_count, 0);
        proc_reset = 1'b0;
        step();
        // single write: ready at T+1, drain visible at T+2, ack pops it
        cache_req(1'b0, 28'h10, DA, cyc, q);
        chk("w1_lat", cyc, 1);
        chk("w1_pulse", c_bus.ready, 0);
        chk("w1_mem_wr", mem_bus.write, 1);
        chk("w1_mem_rd", mem_bus.read, 0);
        chk("w1_addr", mem_bus.addr, 28'h10);
        chk("w1_data", mem_bus.wdata, DA);
        step();
        chk("w1_hold", mem_bus.write, 1);
        mem_pulse('0);
        chk("w1_done", mem_bus.write, 0);
        chk("w1_count", dut.u_fifo.r_count, 0);
        // coalesce behind an in-flight drain
        cache_req(1'b0, 28'h30, DD, cyc, q);
        cache_req(1'b0, 28'h10, DA, cyc, q);
        chk("co_lat_a", cyc, 1);
        cache_req(1'b0, 28'h10, DB, cyc, q);
        chk("co_lat_b", cyc, 1);
        chk("co_count", dut.u_fifo.r_count, 2);
        mem_pulse('0);
        step();
        chk("co_mem_wr", mem_bus.write, 1);
        chk("co_addr", mem_bus.addr, 28'h10);
        chk("co_data", mem_bus.wdata, DB);
        drain_all();
        // write to the line being drained waits for the pop, then becomes a new entry
        cache_req(1'b0, 28'h50, DE, cyc, q);
        fork
            cache_req(1'b0, 28'h50, DF, cyc, q);
            begin
                repeat (3) step();
                mem_pulse('0);
            end
        join
        chk("hb_lat", cyc, 4);
        chk("hb_mem_wr", mem_bus.write, 1);
        chk("hb_data", mem_bus.wdata, DF);
        drain_all();
        // five writes with memory stalled: the fifth is taken on the pop cycle
        for (int i = 0; i < 4; i++) begin
            cache_req(1'b0, 28'h100 + 28'(i), {4{32'h100 + 32'(i)}}, cyc, q);
            chk("full_lat", cyc, 1);
        end
        chk("full_count", dut.u_fifo.r_count, 4);
        fork
            cache_req(1'b0, 28'h104, {4{32'h104}}, cyc5, q5);
            begin
                repeat (2) step();
                mem_pulse('0);
            end
        join
        chk("full_lat5", cyc5, 3);
        chk("full_count5", dut.u_fifo.r_count, 4);
        drain_all();
        // read hit on the entry being drained
        cache_req(1'b0, 28'h20, DC, cyc, q);
        cache_req(1'b1, 28'h20, '0, cyc, q);
        chk("rh_lat", cyc, 1);
        chk("rh_data", q, DC);
        chk("rh_mem_rd", mem_bus.read, 0);
        drain_all();
        // read miss waits for the current drain, then goes ahead of the next one
        cache_req(1'b0, 28'h30, DG, cyc, q);
        cache_req(1'b0, 28'h60, DH, cyc, q);
        fork
            cache_req(1'b1, 28'h40, '0, cyc, q);
            begin
                repeat (2) step();
                chk("rm_wait_rd", mem_bus.read, 0);
                chk("rm_wait_wr", mem_bus.write, 1);
                mem_pulse('0);
                step();
                chk("rm_rd", mem_bus.read, 1);
                chk("rm_wr", mem_bus.write, 0);
                chk("rm_addr", mem_bus.addr, 28'h40);
                mem_pulse(DR);
            end
        join
        chk("rm_lat", cyc, 5);
        chk("rm_data", q, DR);
        chk("rm_rd_off", mem_bus.read, 0);
        drain_all();
        // reset while draining drops the write at once
        cache_req(1'b0, 28'h70, DA, cyc, q);
        chk("rs_pre", mem_bus.write, 1);
        #2 proc_reset = 1'b1;
        #1;
        chk("rs_mem_wr", mem_bus.write, 0);
        chk("rs_count", dut.u_fifo.r_count, 0);
        step();
        chk("rs_c_ready", c_bus.ready, 0);
        proc_reset = 1'b0;
        step();
        chk("rs_idle", mem_bus.write, 0);
        exp_a = '{28'h10, 28'h30, 28'h10, 28'h50, 28'h50, 28'h100, 28'h101, 28'h102, 28'h103, 28'h104, 28'h20, 28'h30, 28'h60};
        exp_d = '{DA, DD, DB, DE, DF, {4{32'h100}}, {4{32'h101}}, {4{32'h102}}, {4{32'h103}}, {4{32'h104}}, DC, DG, DH};
        chk("log_size", wa.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < wa.size(); i++) begin
            chk($sformatf("log_addr%0d", i), wa[i], exp_a[i]);
            chk($sformatf("log_data%0d", i), wd[i], exp_d[i]);
        end
        chk("rlog_size", ra.size(), 1);
        if (ra.size() > 0) chk("rlog_addr", ra[0], 28'h40);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
